mips_multi_ctrl: RTL and testbench
==================================

# mips_multi_ctrl

Main control FSM for the multicycle MIPS core. It sequences the shared datapath: PC register enable, instruction register, unified memory port, ALU operand muxes and register-file writes. It decodes the opcode of the latched instruction and steps through fetch, decode, execute, memory and write-back cycles. It stalls on a memory-ready handshake and drives the PC enable, so it is the only block that advances the program counter.

## Interface
- OPW, 6, opcode width (instr[31:26])
- SW_W, 4, state register width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  OPW  opcode from the instruction register
- zero  in  1  ALU zero flag (combinational, same cycle)
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_en  out  1  PC register enable
- iord  out  1  0 = memory address from PC, 1 = from ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  latch instruction register
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
- illegal  out  1  one-cycle pulse on an unsupported opcode
- state  out  SW_W  current state (debug)

## Operation
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11. Codes 12-15 are unreachable and go to FETCH.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. If mem_ready: ir_write=1, pc_en=1, go to DECODE. Otherwise hold in FETCH with ir_write=0 and pc_en=0.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state:
  - LW/SW → MEMADR
  - RTYPE → RTEX
  - BEQ → BEQEX
  - ADDI → ADDIEX
  - J → JEX
  - any other opcode: illegal=1, go to FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEMRD for LW, MEMWR for SW.
- MEMRD: iord=1, mem_read=1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next state FETCH.
- MEMWR: iord=1, mem_write=1. Hold until mem_ready, then FETCH.
- RTEX: alu_src_a=1, alu_src_b=00, alu_op=10. Next state RTWB.
- RTWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero. Next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- JEX: pc_src=10, pc_en=1. Next state FETCH.
- Outputs not listed for a state are 0.
- Outputs are Moore-decoded from state. The exceptions are pc_en and ir_write in FETCH (gated by mem_ready) and pc_en in BEQEX (gated by zero).

## Timing
- Reset is sampled on the rising edge and sets state=FETCH.
- While reset=1, pc_en, ir_write, reg_write, mem_write, mem_read and illegal are forced to 0. All other outputs then take their FETCH values.
- The first fetch request is issued in the first cycle after reset deasserts.
- Cycles per instruction with zero memory wait: BEQ 3, J 3, RTYPE 4, ADDI 4, SW 4, LW 5.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds exactly 1 cycle.
- mem_read and mem_write stay asserted and stable while stalled.
- pc_en is high for exactly one cycle per FETCH completion, plus one cycle for a taken BEQ or J.
- Reset asserted in any state, including mid-stall, returns to FETCH on the next edge. No pending write completes, because mem_write is forced low in the reset cycle.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.

## Test plan
- Reset sequence: hold reset 3 cycles, then release. state=0 and pc_en=0 during reset; mem_read=1 and iord=0 in the first cycle after release.
- LW with mem_ready=1 always: state sequence 0,1,2,3,4,0. pc_en is high only in cycle 0; reg_write=1 with mem_to_reg=1 in state 4.
- SW with mem_ready low for 2 cycles in MEMWR: state sequence 0,1,2,5,5,5,0. mem_write stays high for all 3 cycles in state 5.
- BEQ, zero=1 then zero=0: pc_en=1 with pc_src=01 in state 8 for the first, pc_en=0 for the second. Both take 3 cycles.
- RTYPE, ADDI and J back-to-back: total 11 cycles. J drives pc_src=10 with pc_en=1 in state 11.
- Illegal opcode 111111: illegal pulses 1 cycle in DECODE, then state returns to 0. Separately, reset asserted in MEMRD returns state to 0 on the next edge.

Source files
------------

// File: rtl/mips_multi_ctrl.sv
// Main control FSM for the multicycle MIPS core: sequences fetch, decode,
// execute, memory and write-back over the shared datapath, stalls on
// mem_ready, and is the only source of the PC enable.
module mips_multi_ctrl #(
   parameter int unsigned OPW  = 6,
   parameter int unsigned SW_W = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [OPW-1:0]  opcode,
   input  logic            zero,
   input  logic            mem_ready,
   output logic            pc_en,
   output logic            iord,
   output logic            mem_read,
   output logic            mem_write,
   output logic            ir_write,
   output logic            reg_dst,
   output logic            mem_to_reg,
   output logic            reg_write,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [1:0]      alu_op,
   output logic [1:0]      pc_src,
   output logic            illegal,
   output logic [SW_W-1:0] state
);

   localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
   localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
   localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
   localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
   localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
   localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

   typedef enum logic [SW_W-1:0] {
      S_FETCH  = SW_W'(0),
      S_DECODE = SW_W'(1),
      S_MEMADR = SW_W'(2),
      S_MEMRD  = SW_W'(3),
      S_MEMWB  = SW_W'(4),
      S_MEMWR  = SW_W'(5),
      S_RTEX   = SW_W'(6),
      S_RTWB   = SW_W'(7),
      S_BEQEX  = SW_W'(8),
      S_ADDIEX = SW_W'(9),
      S_ADDIWB = SW_W'(10),
      S_JEX    = SW_W'(11)
   } state_t;

   state_t r_state;
   state_t w_dec_state;
   logic   w_op_legal;

   assign w_op_legal = (opcode == OP_RTYPE) || (opcode == OP_LW)   ||
                       (opcode == OP_SW)    || (opcode == OP_BEQ)  ||
                       (opcode == OP_ADDI)  || (opcode == OP_J);

   assign state = r_state;

   // State sequencing; memory states hold until mem_ready, stray codes recover to FETCH
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         case (r_state)
            S_FETCH:  if (mem_ready) r_state <= S_DECODE;
            S_DECODE: begin
               case (opcode)
                  OP_LW, OP_SW: r_state <= S_MEMADR;
                  OP_RTYPE:     r_state <= S_RTEX;
                  OP_BEQ:       r_state <= S_BEQEX;
                  OP_ADDI:      r_state <= S_ADDIEX;
                  OP_J:         r_state <= S_JEX;
                  default:      r_state <= S_FETCH;
               endcase
            end
            S_MEMADR: r_state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) r_state <= S_MEMWB;
            S_MEMWB:  r_state <= S_FETCH;
            S_MEMWR:  if (mem_ready) r_state <= S_FETCH;
            S_RTEX:   r_state <= S_RTWB;
            S_RTWB:   r_state <= S_FETCH;
            S_BEQEX:  r_state <= S_FETCH;
            S_ADDIEX: r_state <= S_ADDIWB;
            S_ADDIWB: r_state <= S_FETCH;
            S_JEX:    r_state <= S_FETCH;
            default:  r_state <= S_FETCH;
         endcase
      end
   end

   // Moore decode of datapath controls; handshake/zero gating is same-cycle so
   // the PC and IR update on the edge that completes the access or branch
   always_comb begin
      pc_en       = 1'b0;
      iord        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      alu_op      = 2'b00;
      pc_src      = 2'b00;
      illegal     = 1'b0;
      w_dec_state = reset ? S_FETCH : r_state;
      case (w_dec_state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            pc_en     = mem_ready;
            ir_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            illegal   = ~w_op_legal;
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            iord     = 1'b1;
            mem_read = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         S_RTEX: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_RTWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BEQEX: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_src    = 2'b01;
            pc_en     = zero;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
         end
         S_JEX: begin
            pc_src = 2'b10;
            pc_en  = 1'b1;
         end
         default: ;
      endcase
      // Reset suppresses every side effect so no pending access completes
      if (reset) begin
         pc_en     = 1'b0;
         ir_write  = 1'b0;
         reg_write = 1'b0;
         mem_write = 1'b0;
         mem_read  = 1'b0;
         illegal   = 1'b0;
      end
   end

endmodule

// File: tb/tb_mips_multi_ctrl.sv
// Bench for mips_multi_ctrl: directed instruction table, reset corner cases,
// and random instruction streams against a path-based reference model.
module tb_mips_multi_ctrl;

   localparam int unsigned OPW  = 6;
   localparam int unsigned SW_W = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [OPW-1:0]  opcode;
   logic            zero;
   logic            mem_ready;
   logic            pc_en, iord, mem_read, mem_write, ir_write;
   logic            reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
   logic [1:0]      alu_src_b, alu_op, pc_src;
   logic [SW_W-1:0] state;

   mips_multi_ctrl #(.OPW(OPW), .SW_W(SW_W)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_src(pc_src), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       pc_en;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       illegal;
      logic [3:0] state;
   } obs_t;

   typedef struct {
      string      nm;
      logic [5:0] op;
      logic       z;
      logic [63:0] rdy;
      int         exp_cycles;
      int         exp_pcen;
   } vec_t;

   localparam logic [5:0] RTYPE = 6'b000000;
   localparam logic [5:0] LW    = 6'b100011;
   localparam logic [5:0] SW    = 6'b101011;
   localparam logic [5:0] BEQ   = 6'b000100;
   localparam logic [5:0] ADDI  = 6'b001000;
   localparam logic [5:0] JMP   = 6'b000010;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic obs_t observe();
      obs_t o;
      o.pc_en = pc_en;           o.iord = iord;
      o.mem_read = mem_read;     o.mem_write = mem_write;
      o.ir_write = ir_write;     o.reg_dst = reg_dst;
      o.mem_to_reg = mem_to_reg; o.reg_write = reg_write;
      o.alu_src_a = alu_src_a;   o.alu_src_b = alu_src_b;
      o.alu_op = alu_op;         o.pc_src = pc_src;
      o.illegal = illegal;       o.state = state;
      return o;
   endfunction

   function automatic bit is_legal(input logic [5:0] op);
      return op inside {RTYPE, LW, SW, BEQ, ADDI, JMP};
   endfunction

   // Control word the datapath needs in each step, from the state table
   function automatic obs_t spec_obs(input int s, input logic rdy, input logic z,
                                     input logic [5:0] op);
      obs_t o = '0;
      o.state = 4'(s);
      case (s)
         0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.pc_en = rdy; o.ir_write = rdy; end
         1:  begin o.alu_src_b = 2'b11; o.illegal = !is_legal(op); end
         2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
         3:  begin o.iord = 1; o.mem_read = 1; end
         4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
         5:  begin o.iord = 1; o.mem_write = 1; end
         6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
         7:  begin o.reg_write = 1; o.reg_dst = 1; end
         8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.pc_en = z; end
         9:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
         10: o.reg_write = 1;
         11: begin o.pc_src = 2'b10; o.pc_en = 1; end
         default: ;
      endcase
      return o;
   endfunction

   task automatic drive(input logic rst, input logic [5:0] op, input logic z, input logic rdy);
      @(negedge clk);
      reset = rst; opcode = op; zero = z; mem_ready = rdy;
      #1;
   endtask

   // Walk one instruction along its step list; memory steps repeat while not ready
   task automatic run_instr(input string nm, input logic [5:0] op, input logic z,
                            input logic [63:0] rdy_pat, output int cycles, output int pcen_cnt);
      int   path[$];
      int   idx;
      int   s;
      logic r;
      obs_t a, e;
      path = {0, 1};
      case (op)
         RTYPE:   begin path.push_back(6); path.push_back(7); end
         LW:      begin path.push_back(2); path.push_back(3); path.push_back(4); end
         SW:      begin path.push_back(2); path.push_back(5); end
         BEQ:     path.push_back(8);
         ADDI:    begin path.push_back(9); path.push_back(10); end
         JMP:     path.push_back(11);
         default: ;
      endcase
      idx = 0; cycles = 0; pcen_cnt = 0;
      while (idx < path.size() && cycles < 64) begin
         r = rdy_pat[cycles];
         drive(1'b0, op, z, r);
         s = path[idx];
         a = observe();
         e = spec_obs(s, r, z, op);
         chk($sformatf("%s cyc%0d", nm, cycles), {12'd0, a}, {12'd0, e});
         if (a.pc_en) pcen_cnt++;
         if (!((s == 0 || s == 3 || s == 5) && !r)) idx++;
         cycles++;
      end
      if (idx < path.size()) chk({nm, " timeout"}, 32'(1), 32'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[10];
      int   cyc, pce, total;
      logic [63:0] pat;
      logic [5:0]  op;
      logic [5:0]  ops[6];

      vt[0] = '{"lw",        LW,        1'b0, '1,      5, 1};
      vt[1] = '{"sw_stall",  SW,        1'b0, 64'h21,  6, 1};
      vt[2] = '{"beq_taken", BEQ,       1'b1, '1,      3, 2};
      vt[3] = '{"beq_not",   BEQ,       1'b0, '1,      3, 1};
      vt[4] = '{"rtype",     RTYPE,     1'b0, '1,      4, 1};
      vt[5] = '{"addi",      ADDI,      1'b0, '1,      4, 1};
      vt[6] = '{"j",         JMP,       1'b0, '1,      3, 2};
      vt[7] = '{"ill_3f",    6'b111111, 1'b0, '1,      2, 1};
      vt[8] = '{"lw_stall",  LW,        1'b1, 64'h22,  7, 1};
      vt[9] = '{"ill_01",    6'b000001, 1'b1, 64'h1,   2, 1};

      reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b1;

      // Reset held three cycles: FETCH controls, side effects suppressed
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, LW, 1'b0, 1'b1);
         chk("rst state",     32'(state), 32'(0));
         chk("rst pc_en",     32'(pc_en), 32'(0));
         chk("rst mem_read",  32'(mem_read), 32'(0));
         chk("rst ir_write",  32'(ir_write), 32'(0));
         chk("rst alu_src_b", 32'(alu_src_b), 32'(1));
      end
      drive(1'b0, LW, 1'b0, 1'b0);
      chk("post-rst mem_read", 32'(mem_read), 32'(1));
      chk("post-rst iord",     32'(iord), 32'(0));
      chk("post-rst state",    32'(state), 32'(0));
      chk("post-rst pc_en",    32'(pc_en), 32'(0));

      // Directed instruction table
      total = 0;
      for (int i = 0; i < 10; i++) begin
         run_instr(vt[i].nm, vt[i].op, vt[i].z, vt[i].rdy, cyc, pce);
         chk({vt[i].nm, " cycles"}, 32'(cyc), 32'(vt[i].exp_cycles));
         chk({vt[i].nm, " pc_en count"}, 32'(pce), 32'(vt[i].exp_pcen));
         if (i >= 4 && i <= 6) total += cyc;
         drive(1'b0, RTYPE, 1'b0, 1'b0);
         chk({vt[i].nm, " back to fetch"}, 32'(state), 32'(0));
      end
      chk("rtype+addi+j cycles", 32'(total), 32'(11));

      // Reset while stalled in MEMRD
      drive(1'b0, LW, 1'b0, 1'b1);
      drive(1'b0, LW, 1'b0, 1'b1);
      drive(1'b0, LW, 1'b0, 1'b1);
      drive(1'b0, LW, 1'b0, 1'b0);
      chk("memrd state", 32'(state), 32'(3));
      chk("memrd mem_read", 32'(mem_read), 32'(1));
      drive(1'b1, LW, 1'b0, 1'b1);
      chk("memrd rst mem_read", 32'(mem_read), 32'(0));
      chk("memrd rst reg_write", 32'(reg_write), 32'(0));
      drive(1'b0, LW, 1'b0, 1'b0);
      chk("memrd rst -> fetch", 32'(state), 32'(0));

      // Reset while stalled in MEMWR: the write must not complete
      drive(1'b0, SW, 1'b0, 1'b1);
      drive(1'b0, SW, 1'b0, 1'b1);
      drive(1'b0, SW, 1'b0, 1'b1);
      drive(1'b0, SW, 1'b0, 1'b0);
      chk("memwr state", 32'(state), 32'(5));
      chk("memwr mem_write", 32'(mem_write), 32'(1));
      drive(1'b1, SW, 1'b0, 1'b1);
      chk("memwr rst mem_write", 32'(mem_write), 32'(0));
      chk("memwr rst iord", 32'(iord), 32'(0));
      drive(1'b0, SW, 1'b0, 1'b0);
      chk("memwr rst -> fetch", 32'(state), 32'(0));
      chk("memwr rst no write", 32'(mem_write), 32'(0));

      // Random instruction stream with random memory waits
      ops = '{RTYPE, LW, SW, BEQ, ADDI, JMP};
      for (int n = 0; n < 120; n++) begin
         int k;
         k = $urandom_range(0, 6);
         op = (k == 6) ? 6'($urandom) : ops[k];
         pat = '1;
         for (int b = 0; b < 20; b++) pat[b] = ($urandom_range(0, 2) != 0);
         run_instr($sformatf("rnd%0d op%0h", n, op), op, 1'($urandom), pat, cyc, pce);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
